// File: rtl/sdram_line_addr_seg_gen_pkg.sv
// Shared SDRAM line-buffer control definitions: segment count helper,
// read base derivation from the scale offset, and the default write wrap point.
package sdram_line_addr_seg_gen_pkg;

  // Last write address of a 800-pixel line buffer.
  localparam int DEF_LINE_MAX_WR = 799;

  // Read-line sequencing state: idle between lines, active while walking one.
  typedef enum logic {
    LINE_IDLE   = 1'b0,
    LINE_ACTIVE = 1'b1
  } line_state_t;

  // Number of refill segments per line.
  function automatic int nseg_of(input int seg_log2);
    return 1 << seg_log2;
  endfunction

  // The scale offset counts pixel pairs, so the read base is twice the offset.
  function automatic int base_from_offset(input int offset);
    return offset * 2;
  endfunction

endpackage

// File: rtl/sdram_line_addr_seg_gen_if.sv
// Bus between the line-address generator and its neighbours: write-side
// advance, read-line control/config, and the refill request handshake.
interface sdram_line_addr_seg_gen_if #(
  parameter int ADDR_W   = 11,
  parameter int OFFSET_W = 7,
  parameter int SEG_LOG2 = 3
);
  localparam int NSEG = 1 << SEG_LOG2;

  logic                iWR_CLR;
  logic                iEN_W;
  logic                iLINE_START;
  logic                iEN_R;
  logic                iREQ_CLR;
  logic                iOVF_CLR;
  logic [ADDR_W-1:0]   iREG_SCALE_WIDTH;
  logic [OFFSET_W-1:0] iREG_SCALE_OFFSET;
  logic                iREG_MIRROR;
  logic [NSEG-1:0]     iREG_SEG_MASK;

  logic [ADDR_W-1:0]   oADDR_W;
  logic [ADDR_W-1:0]   oADDR_R;
  logic                oREQ_W;
  logic [SEG_LOG2-1:0] oREQ_SEG;
  logic                oLINE_DONE;
  logic                oOVF;

  // Driver side: FIFO control / display timing.
  modport master (
    output iWR_CLR, iEN_W, iLINE_START, iEN_R, iREQ_CLR, iOVF_CLR,
    output iREG_SCALE_WIDTH, iREG_SCALE_OFFSET, iREG_MIRROR, iREG_SEG_MASK,
    input  oADDR_W, oADDR_R, oREQ_W, oREQ_SEG, oLINE_DONE, oOVF
  );

  // Address generator side.
  modport slave (
    input  iWR_CLR, iEN_W, iLINE_START, iEN_R, iREQ_CLR, iOVF_CLR,
    input  iREG_SCALE_WIDTH, iREG_SCALE_OFFSET, iREG_MIRROR, iREG_SEG_MASK,
    output oADDR_W, oADDR_R, oREQ_W, oREQ_SEG, oLINE_DONE, oOVF
  );

endinterface

// File: rtl/sdram_line_addr_seg_gen_pend.sv
// Pending refill request counter: counts boundary events up, acknowledges
// down, saturates at all-ones and flags a lost request as sticky overflow.
module sdram_req_pend_cnt
  import sdram_line_addr_seg_gen_pkg::*;
#(
  parameter int PEND_W = 3
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iEVENT,
  input  logic              iCLR,
  input  logic              iOVF_CLR,
  output logic [PEND_W-1:0] oPEND,
  output logic              oOVF
);

  typedef logic [PEND_W-1:0] pend_t;

  pend_t pend_reg, pend_next;
  logic  ovf_reg, ovf_next;

  // Next count: simultaneous event and ack cancel; overflow set beats clear.
  always_comb begin
    pend_next = pend_reg;
    ovf_next  = ovf_reg;
    if (iOVF_CLR) begin
      ovf_next = 1'b0;
    end
    if (iEVENT && !iCLR) begin
      if (pend_reg == '1) begin
        ovf_next = 1'b1;
      end else begin
        pend_next = pend_reg + pend_t'(1);
      end
    end else if (iCLR && !iEVENT && (pend_reg != '0)) begin
      pend_next = pend_reg - pend_t'(1);
    end
  end

  // Counter and sticky overflow registers.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pend_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign oPEND = pend_reg;
  assign oOVF  = ovf_reg;

endmodule

// File: rtl/sdram_line_addr_seg_gen.sv
// Line-buffer address generator for the SDRAM read path: wrapping write
// address, scaled/mirrored read address walk, and segment-boundary refill
// requests counted by a pending-request counter.
module sdram_line_addr_seg_gen
  import sdram_line_addr_seg_gen_pkg::*;
#(
  parameter int ADDR_W      = 11,
  parameter int LINE_MAX_WR = DEF_LINE_MAX_WR,
  parameter int OFFSET_W    = 7,
  parameter int SEG_LOG2    = 3,
  parameter int PEND_W      = 3
) (
  input logic                       iCLK,
  input logic                       iRST_n,
  sdram_line_addr_seg_gen_if.slave  bus
);

  localparam int NSEG  = nseg_of(SEG_LOG2);
  localparam int ACC_W = ADDR_W + SEG_LOG2 + 1;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [ADDR_W:0]     tgt_t;
  typedef logic [ACC_W-1:0]    acc_t;
  typedef logic [SEG_LOG2-1:0] seg_t;

  // Write side
  addr_t addr_w_reg, addr_w_next;

  // Read side state and shadowed line configuration
  line_state_t     state_reg, state_next;
  addr_t           pos_reg, pos_next;
  acc_t            acc_reg, acc_next;
  seg_t            seg_reg, seg_next;
  seg_t            req_seg_reg, req_seg_next;
  addr_t           width_reg, width_next;
  addr_t           base_reg, base_next;
  logic            mirror_reg, mirror_next;
  logic [NSEG-1:0] mask_reg, mask_next;
  addr_t           addr_r_reg, addr_r_next;
  logic            done_reg, done_next;

  // Boundary detection
  logic [NSEG-1:0]   mask_eff;
  tgt_t              target;
  logic              small_w;
  logic              adv;
  logic              any_hit;
  logic              final_hit;
  logic              req_event;
  logic [PEND_W-1:0] pend;
  logic              ovf;

  // The last segment boundary ends the line, so its request can never be masked.
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_mask
    assign mask_eff[gi] = bus.iREG_SEG_MASK[gi] | 1'(gi == NSEG - 1);
  end

  // Boundary k sits at floor(k*W/NSEG)-1; acc carries k*W.
  assign target  = acc_reg[ACC_W-1:SEG_LOG2] - tgt_t'(1);
  // Below NSEG pixels the intermediate boundaries collapse; only the line end counts.
  assign small_w = ((width_reg >> SEG_LOG2) == '0);
  assign adv     = (state_reg == LINE_ACTIVE) && bus.iEN_R && !bus.iLINE_START;

  // Hit detection on the position being consumed by this read advance.
  always_comb begin
    any_hit   = 1'b0;
    final_hit = 1'b0;
    if (adv) begin
      if (small_w) begin
        any_hit   = (pos_reg == width_reg - addr_t'(1));
        final_hit = any_hit;
      end else begin
        any_hit   = ({1'b0, pos_reg} == target);
        final_hit = any_hit && (seg_reg == seg_t'(NSEG - 1));
      end
    end
  end

  assign req_event = any_hit && (mask_reg[seg_reg] || final_hit);

  // Write address: clear wins over advance; wraps after LINE_MAX_WR.
  always_comb begin
    addr_w_next = addr_w_reg;
    if (bus.iWR_CLR) begin
      addr_w_next = '0;
    end else if (bus.iEN_W) begin
      addr_w_next = (addr_w_reg == addr_t'(LINE_MAX_WR)) ? '0 : addr_w_reg + addr_t'(1);
    end
  end

  // Read-line FSM and datapath next state: start snapshots config, advance walks pos.
  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    acc_next     = acc_reg;
    seg_next     = seg_reg;
    req_seg_next = req_seg_reg;
    width_next   = width_reg;
    base_next    = base_reg;
    mirror_next  = mirror_reg;
    mask_next    = mask_reg;
    done_next    = 1'b0;
    if (bus.iLINE_START) begin
      width_next  = bus.iREG_SCALE_WIDTH;
      base_next   = addr_t'(base_from_offset(int'(bus.iREG_SCALE_OFFSET)));
      mirror_next = bus.iREG_MIRROR;
      mask_next   = mask_eff;
      pos_next    = '0;
      acc_next    = acc_t'(bus.iREG_SCALE_WIDTH);
      seg_next    = '0;
      if (bus.iREG_SCALE_WIDTH == '0) begin
        state_next = LINE_IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = LINE_ACTIVE;
      end
    end else if (adv) begin
      if (any_hit) begin
        acc_next     = acc_reg + acc_t'(width_reg);
        seg_next     = seg_reg + seg_t'(1);
        req_seg_next = final_hit ? seg_t'(NSEG - 1) : seg_reg;
      end
      if (final_hit) begin
        // pos stays on the last pixel so the read address holds at line end.
        state_next = LINE_IDLE;
        done_next  = 1'b1;
      end else begin
        pos_next = pos_reg + addr_t'(1);
      end
    end
  end

  // Read address follows the next pos so it is valid the cycle after a change.
  always_comb begin
    if (mirror_next) begin
      addr_r_next = base_next + width_next - addr_t'(1) - pos_next;
    end else begin
      addr_r_next = base_next + pos_next;
    end
  end

  // State and output registers.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      addr_w_reg  <= '0;
      state_reg   <= LINE_IDLE;
      pos_reg     <= '0;
      acc_reg     <= '0;
      seg_reg     <= '0;
      req_seg_reg <= '0;
      width_reg   <= '0;
      base_reg    <= '0;
      mirror_reg  <= 1'b0;
      mask_reg    <= '0;
      addr_r_reg  <= '0;
      done_reg    <= 1'b0;
    end else begin
      addr_w_reg  <= addr_w_next;
      state_reg   <= state_next;
      pos_reg     <= pos_next;
      acc_reg     <= acc_next;
      seg_reg     <= seg_next;
      req_seg_reg <= req_seg_next;
      width_reg   <= width_next;
      base_reg    <= base_next;
      mirror_reg  <= mirror_next;
      mask_reg    <= mask_next;
      addr_r_reg  <= addr_r_next;
      done_reg    <= done_next;
    end
  end

  sdram_req_pend_cnt #(
    .PEND_W (PEND_W)
  ) u_pend (
    .iCLK     (iCLK),
    .iRST_n   (iRST_n),
    .iEVENT   (req_event),
    .iCLR     (bus.iREQ_CLR),
    .iOVF_CLR (bus.iOVF_CLR),
    .oPEND    (pend),
    .oOVF     (ovf)
  );

  assign bus.oADDR_W    = addr_w_reg;
  assign bus.oADDR_R    = addr_r_reg;
  assign bus.oREQ_W     = (pend != '0);
  assign bus.oREQ_SEG   = req_seg_reg;
  assign bus.oLINE_DONE = done_reg;
  assign bus.oOVF       = ovf;

endmodule

// File: tb/tb_sdram_line_addr_seg_gen.sv
// Scoreboard bench for sdram_line_addr_seg_gen: the driver queues the expected
// outputs for every clocked step, the monitor pops and compares after each edge.
module tb_sdram_line_addr_seg_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_line_addr_seg_gen_if #(.ADDR_W(11), .OFFSET_W(7), .SEG_LOG2(3)) bus();

  sdram_line_addr_seg_gen #(
    .ADDR_W(11), .LINE_MAX_WR(799), .OFFSET_W(7), .SEG_LOG2(3), .PEND_W(3)
  ) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int aw;
    int ar;
    int req;
    int seg;
    int done;
    int ovf;
    int tid;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int test_id = 0;

  int exp_aw = 0;
  int exp_ar = 0;
  int exp_pend = 0;
  int exp_seg = 0;
  int exp_done = 0;
  int exp_ovf = 0;

  task automatic chk(input string name, input int tid, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s test=%0d actual=%0d required=%0d", name, tid, act, req);
    end
  endtask

  // Monitor: one expected record per driven clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("addr_w",    e.tid, int'(bus.oADDR_W),    e.aw);
        chk("addr_r",    e.tid, int'(bus.oADDR_R),    e.ar);
        chk("req_w",     e.tid, int'(bus.oREQ_W),     e.req);
        chk("req_seg",   e.tid, int'(bus.oREQ_SEG),   e.seg);
        chk("line_done", e.tid, int'(bus.oLINE_DONE), e.done);
        chk("ovf",       e.tid, int'(bus.oOVF),       e.ovf);
      end
    end
  end

  task automatic tick();
    exp_t e;
    @(posedge clk);
    e.aw = exp_aw; e.ar = exp_ar; e.req = (exp_pend != 0) ? 1 : 0;
    e.seg = exp_seg; e.done = exp_done; e.ovf = exp_ovf; e.tid = test_id;
    sb_q.push_back(e);
    @(negedge clk);
    bus.iWR_CLR = 1'b0; bus.iEN_W = 1'b0; bus.iLINE_START = 1'b0;
    bus.iEN_R = 1'b0; bus.iREQ_CLR = 1'b0; bus.iOVF_CLR = 1'b0;
    exp_done = 0;
  endtask

  task automatic pend_upd(input bit ev, input bit clr);
    if (ev && !clr) begin
      if (exp_pend == 7) exp_ovf = 1;
      else exp_pend++;
    end else if (clr && !ev && exp_pend != 0) begin
      exp_pend--;
    end
  endtask

  function automatic int addr_of(input int base, input int w, input bit mir, input int pos);
    if (mir) return (base + w - 1 - pos) & 2047;
    return (base + pos) & 2047;
  endfunction

  // ack_mode: 0 = never ack, 1 = ack the cycle after each request, 2 = ack on the event cycle.
  task automatic run_line(input int w, input int off, input bit mir, input logic [7:0] mask,
                          input int ack_mode, input int n_steps);
    int base, k;
    bit hit, fin, ev, clr, prev_ev;
    base = off * 2;
    bus.iREG_SCALE_WIDTH = 11'(w);
    bus.iREG_SCALE_OFFSET = 7'(off);
    bus.iREG_MIRROR = mir;
    bus.iREG_SEG_MASK = mask;
    bus.iLINE_START = 1'b1;
    exp_ar = addr_of(base, w, mir, 0);
    exp_done = (w == 0) ? 1 : 0;
    tick();
    k = 1;
    prev_ev = 1'b0;
    for (int p = 0; p < n_steps; p++) begin
      bus.iEN_R = 1'b1;
      clr = (ack_mode == 1) && prev_ev;
      hit = 1'b0;
      fin = 1'b0;
      if (p < w) begin
        if (w >= 8) hit = (p == (k * w) / 8 - 1);
        else hit = (p == w - 1);
        fin = hit && (p == w - 1);
      end
      ev = hit && (fin || mask[(k - 1) & 7]);
      if (ack_mode == 2) clr = ev;
      bus.iREQ_CLR = clr;
      pend_upd(ev, clr);
      if (hit) begin
        exp_seg = fin ? 7 : k - 1;
        k++;
      end
      if (p < w) exp_ar = addr_of(base, w, mir, (p + 1 < w) ? p + 1 : w - 1);
      exp_done = fin ? 1 : 0;
      tick();
      prev_ev = ev;
    end
  endtask

  task automatic ack_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.iREQ_CLR = 1'b1;
      pend_upd(1'b0, 1'b1);
      tick();
    end
  endtask

  initial begin
    bus.iWR_CLR = 1'b0; bus.iEN_W = 1'b0; bus.iLINE_START = 1'b0;
    bus.iEN_R = 1'b0; bus.iREQ_CLR = 1'b0; bus.iOVF_CLR = 1'b0;
    bus.iREG_SCALE_WIDTH = '0; bus.iREG_SCALE_OFFSET = '0;
    bus.iREG_MIRROR = 1'b0; bus.iREG_SEG_MASK = '0;
    @(negedge clk);

    // Reset values, then release.
    test_id = 0;
    bus.iEN_W = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    $display("test 0: reset state");

    // Write address wrap and clear priority.
    test_id = 1;
    for (int i = 0; i < 800; i++) begin
      bus.iEN_W = 1'b1;
      exp_aw = (exp_aw == 799) ? 0 : exp_aw + 1;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      bus.iEN_W = 1'b1;
      exp_aw++;
      tick();
    end
    bus.iEN_W = 1'b1; bus.iWR_CLR = 1'b1;
    exp_aw = 0;
    tick();
    $display("test 1: write address 800-step wrap and clear");

    test_id = 2;
    run_line(800, 5, 1'b0, 8'hFF, 1, 801);
    $display("test 2: W=800 offset=5 forward line, acked requests");

    test_id = 3;
    run_line(16, 0, 1'b1, 8'hFF, 1, 17);
    $display("test 3: W=16 mirrored line");

    test_id = 4;
    run_line(4, 0, 1'b0, 8'hFF, 1, 5);
    $display("test 4: W=4 single final request");

    test_id = 5;
    run_line(0, 3, 1'b0, 8'hFF, 0, 2);
    $display("test 5: W=0 immediate line done");

    test_id = 6;
    run_line(800, 0, 1'b0, 8'h0F, 0, 800);
    ack_n(5);
    ack_n(1);
    $display("test 6: mask 0F unacked requests drain after five acks");

    test_id = 7;
    run_line(16, 0, 1'b0, 8'h01, 0, 17);
    run_line(16, 0, 1'b0, 8'h00, 2, 17);
    ack_n(2);
    $display("test 7: event with simultaneous ack holds count");

    test_id = 8;
    run_line(800, 0, 1'b0, 8'hFF, 0, 801);
    bus.iOVF_CLR = 1'b1;
    exp_ovf = 0;
    tick();
    ack_n(7);
    $display("test 8: saturation, overflow and overflow clear");

    test_id = 9;
    for (int i = 0; i < 3; i++) begin
      bus.iEN_W = 1'b1;
      exp_aw++;
      tick();
    end
    run_line(800, 0, 1'b0, 8'hFF, 0, 150);
    rst_n = 1'b0;
    exp_aw = 0; exp_ar = 0; exp_pend = 0; exp_seg = 0; exp_ovf = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.iEN_R = 1'b1;
      tick();
    end
    $display("test 9: reset mid-line, read advance without start ignored");

    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_line_addr_seg_gen.md
Name: sdram_line_addr_seg_gen

Overview:
Parametrised line-buffer address generator for the SDRAM read path of the scaler/display pipeline. Produces a free-running wrapping write address for the SDRAM-to-line-buffer side. Produces a read address that walks one scaled line (offset base, forward or mirrored). Raises SDRAM refill requests at NSEG programmable segment boundaries, with a counted, acknowledged pending-request handshake. Single clock domain; sits between the SDRAM read FIFO control and the display timing/scaler logic.

Parameters:
ADDR_W, 11, width of read/write line-buffer addresses
LINE_MAX_WR, 799, last write address before wrap to 0
OFFSET_W, 7, width of scale offset register (base = offset*2)
SEG_LOG2, 3, log2 of segment count NSEG (default 8 segments)
PEND_W, 3, width of pending-request counter

Ports:
iCLK  in  1  clock
iRST_n  in  1  asynchronous active-low reset
iWR_CLR  in  1  sync clear of write address
iEN_W  in  1  write address advance
iLINE_START  in  1  pulse: start new read line, snapshot config
iEN_R  in  1  read address advance
iREQ_CLR  in  1  acknowledge one pending request
iOVF_CLR  in  1  clear sticky overflow
iREG_SCALE_WIDTH  in  ADDR_W  scaled line width W
iREG_SCALE_OFFSET  in  OFFSET_W  read base offset
iREG_MIRROR  in  1  1 = read line in descending order
iREG_SEG_MASK  in  NSEG  bit k-1 enables boundary k (bit NSEG-1 ignored, always on)
oADDR_W  out  ADDR_W  write address
oADDR_R  out  ADDR_R  read address
oREQ_W  out  1  refill request pending (pend != 0)
oREQ_SEG  out  SEG_LOG2  index (k-1) of most recent boundary hit
oLINE_DONE  out  1  one-cycle pulse at line end
oOVF  out  1  sticky: request lost at counter saturation

Behaviour:
- Reset (iRST_n=0, async): oADDR_W=0, oADDR_R=0, pend=0 (oREQ_W=0), oREQ_SEG=0, oLINE_DONE=0, oOVF=0, active=0, pos=0, shadow regs=0.
- Write: iWR_CLR -> oADDR_W=0 (priority over iEN_W). Else iEN_W: oADDR_W==LINE_MAX_WR ? 0 : +1.
- iLINE_START: snapshot W, base={offset,1'b0} zero-extended, mirror into shadow regs. Set pos=0, acc=W, seg=0. Set active=(W!=0); W==0 also pulses oLINE_DONE next cycle.
  - Start beats iEN_R in the same cycle (no advance).
  - Config inputs are ignored mid-line.
- oADDR_R registered = mirror ? base+W-1-pos : base+pos, modulo 2^ADDR_W. Updates the cycle after any pos change or start.
- iEN_R while active: pos+1.
- Boundary k (1..NSEG) hits when the advancing pos equals (acc>>SEG_LOG2)-1, acc = k*W held incrementally.
  - On hit: acc+=W, seg+=1, oREQ_SEG<=seg.
  - If mask bit set or k==NSEG: request event.
  - Hit at k==NSEG (pos==W-1): active<=0, oLINE_DONE pulse. Further iEN_R ignored until next start.
- W<NSEG: only the final boundary generates a request. W>=NSEG guarantees distinct, increasing boundaries.
- Request latency: oREQ_W rises 1 cycle after the iEN_R cycle that hits an enabled boundary.
- Pending counter pend:
  - event & !clr: +1.
  - clr & !event & pend!=0: -1.
  - event & clr: unchanged.
  - clr at pend==0: ignored.
  - event at pend==max: held, oOVF<=1.
- oOVF cleared only by iOVF_CLR (set wins if same cycle) or reset.
- iLINE_START does not clear pend.
- Reset mid-line: all state to reset values immediately; next line needs iLINE_START.

Decomposition:
- Shared sdram control package: NSEG=1<<SEG_LOG2, base-from-offset function, default LINE_MAX_WR.
- One sub-module, sdram_req_pend_cnt: saturating up/down counter with event/clr/overflow, parameter PEND_W.

Test Plan:
- Reset, then 800 iEN_W pulses -> oADDR_W 0..799 then 0; iWR_CLR with iEN_W -> 0.
- W=800, offset=5, mask=8'hFF, mirror=0, start + 800 iEN_R, ack each request -> oADDR_R 10..809. oREQ_W after pos 99,199,...,799 with oREQ_SEG 0..7. oLINE_DONE once, after final hit.
- Mirror=1, W=16, offset=0 -> oADDR_R 15 down to 0; requests at pos 1,3,...,15.
- W=800, mask=8'h0F, no acks -> pend reaches 5 (boundaries 1-4, 8). With PEND_W=2: pend saturates at 3, oOVF=1; iOVF_CLR clears it.
- Event and iREQ_CLR same cycle at pend=2 -> pend stays 2. iREQ_CLR at pend=0 -> stays 0.
- W=4 (<NSEG) -> single request at pos 3.
- iRST_n low mid-line -> all outputs 0; iEN_R without start ignored.
